// File: rtl/echo_feedback.sv
// rtl/echo_feedback.sv - single-tap feedback mixer driving an external fifo_delay line
module echo_feedback #(
    parameter int WIDTH      = 12,
    parameter int GAIN_WIDTH = 8,
    parameter int DROP_WIDTH = 8
) (
    input  logic                           clk,
    input  logic                           rstn,
    input  logic                           sample_valid,
    input  logic signed [WIDTH-1:0]        dry_in,
    input  logic        [GAIN_WIDTH-1:0]   gain,
    input  logic signed [WIDTH-1:0]        delayed_in,
    output logic signed [WIDTH-1:0]        fifo_in,
    output logic                           fifo_enable,
    output logic signed [WIDTH-1:0]        wet_out,
    output logic                           out_valid,
    output logic                           busy,
    output logic        [DROP_WIDTH-1:0]   drop_count
);
    localparam int PW = WIDTH + GAIN_WIDTH + 1;

    typedef enum logic [1:0] {IDLE, MULT, SUM, DONE} state_t;

    state_t                        state_q, state_d;
    logic signed [WIDTH-1:0]       dry_q, dry_d;
    logic signed [WIDTH-1:0]       del_q, del_d;
    logic        [GAIN_WIDTH-1:0]  gain_q, gain_d;
    logic signed [PW-1:0]          prod_q, prod_d;
    logic signed [WIDTH-1:0]       wet_q, wet_d;
    logic                          valid_q, valid_d;
    logic        [DROP_WIDTH-1:0]  drop_q, drop_d;

    logic                          accept;
    logic signed [PW-1:0]          scaled;
    logic        [WIDTH:0]         sum;

    always_comb begin
        state_d = state_q;
        dry_d   = dry_q;
        del_d   = del_q;
        gain_d  = gain_q;
        prod_d  = prod_q;
        wet_d   = wet_q;
        valid_d = 1'b0;
        drop_d  = drop_q;

        accept = sample_valid && (state_q == IDLE || state_q == DONE);
        // Arithmetic shift floors toward -inf; |scaled| < 2^(WIDTH-1) so WIDTH+1 bits hold the sum.
        scaled = prod_q >>> GAIN_WIDTH;
        sum    = {dry_q[WIDTH-1], dry_q} + scaled[WIDTH:0];

        if (accept) begin
            dry_d   = dry_in;
            del_d   = delayed_in;
            gain_d  = gain;
            state_d = MULT;
        end else if (state_q == DONE) begin
            state_d = IDLE;
        end

        case (state_q)
            MULT: begin
                prod_d  = $signed(PW'(del_q)) * $signed(PW'({1'b0, gain_q}));
                state_d = SUM;
            end
            SUM: begin
                if (sum[WIDTH] != sum[WIDTH-1])
                    wet_d = sum[WIDTH] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
                else
                    wet_d = sum[WIDTH-1:0];
                valid_d = 1'b1;
                state_d = DONE;
            end
            default: ;
        endcase

        if (sample_valid && busy && drop_q != {DROP_WIDTH{1'b1}})
            drop_d = drop_q + DROP_WIDTH'(1);
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= IDLE;
            dry_q   <= '0;
            del_q   <= '0;
            gain_q  <= '0;
            prod_q  <= '0;
            wet_q   <= '0;
            valid_q <= 1'b0;
            drop_q  <= '0;
        end else begin
            state_q <= state_d;
            dry_q   <= dry_d;
            del_q   <= del_d;
            gain_q  <= gain_d;
            prod_q  <= prod_d;
            wet_q   <= wet_d;
            valid_q <= valid_d;
            drop_q  <= drop_d;
        end
    end

    assign busy        = (state_q == MULT) || (state_q == SUM);
    assign wet_out     = wet_q;
    assign fifo_in     = wet_q;
    assign out_valid   = valid_q;
    assign fifo_enable = valid_q;
    assign drop_count  = drop_q;

endmodule

// File: tb/tb_echo_feedback.sv
// tb/tb_echo_feedback.sv - directed vector bench for echo_feedback, with a modelled delay line
module tb_echo_feedback;
    logic               clk = 1'b0;
    logic               rstn;
    logic               sample_valid;
    logic signed [11:0] dry_in;
    logic        [7:0]  gain;
    logic signed [11:0] delayed_in;
    logic signed [11:0] fifo_in;
    logic               fifo_enable;
    logic signed [11:0] wet_out;
    logic               out_valid;
    logic               busy;
    logic        [7:0]  drop_count;

    int n_cmp  = 0;
    int n_fail = 0;

    echo_feedback #(.WIDTH(12), .GAIN_WIDTH(8), .DROP_WIDTH(8)) dut (
        .clk(clk), .rstn(rstn), .sample_valid(sample_valid), .dry_in(dry_in),
        .gain(gain), .delayed_in(delayed_in), .fifo_in(fifo_in),
        .fifo_enable(fifo_enable), .wet_out(wet_out), .out_valid(out_valid),
        .busy(busy), .drop_count(drop_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        int dry;
        int del;
        int g;
        int exp_wet;
    } vec_t;

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Strobe one sample at the next edge and follow it to its DONE cycle.
    task automatic run_sample(input int dry, input int del, input int g,
                              output int wet, output int fin, output bit fen);
        dry_in       = 12'(dry);
        delayed_in   = 12'(del);
        gain         = 8'(g);
        sample_valid = 1'b1;
        @(negedge clk);
        sample_valid = 1'b0;
        check("busy_mult", int'(busy), 1);
        check("ov_mult", int'(out_valid), 0);
        @(negedge clk);
        check("busy_sum", int'(busy), 1);
        check("fen_sum", int'(fifo_enable), 0);
        @(negedge clk);
        check("busy_done", int'(busy), 0);
        check("ov_done", int'(out_valid), 1);
        wet = int'(wet_out);
        fin = int'(fifo_in);
        fen = fifo_enable;
    endtask

    vec_t vecs[10];
    logic signed [11:0] hist[10];

    initial begin
        int wet, fin, cnt;
        bit fen;

        vecs[0] = '{100, 555, 0, 100};
        vecs[1] = '{2047, 2047, 128, 2047};
        vecs[2] = '{-2048, -2048, 255, -2048};
        vecs[3] = '{100, -3, 128, 98};
        vecs[4] = '{100, 3, 128, 101};
        vecs[5] = '{0, -1, 1, -1};
        vecs[6] = '{500, 1000, 64, 750};
        vecs[7] = '{-100, -1000, 200, -882};
        vecs[8] = '{2000, 2047, 255, 2047};
        vecs[9] = '{-2048, 0, 255, -2048};

        rstn = 1'b0; sample_valid = 1'b0; dry_in = '0; gain = '0; delayed_in = '0;
        repeat (2) @(negedge clk);
        check("rst_wet", int'(wet_out), 0);
        check("rst_fifo_in", int'(fifo_in), 0);
        check("rst_fen", int'(fifo_enable), 0);
        check("rst_ov", int'(out_valid), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_drop", int'(drop_count), 0);
        rstn = 1'b1;
        @(negedge clk);

        foreach (vecs[i]) begin
            run_sample(vecs[i].dry, vecs[i].del, vecs[i].g, wet, fin, fen);
            check($sformatf("vec%0d_wet", i), wet, vecs[i].exp_wet);
            check($sformatf("vec%0d_fifo_in", i), fin, vecs[i].exp_wet);
            check($sformatf("vec%0d_fen", i), int'(fen), 1);
            @(negedge clk);
            check($sformatf("vec%0d_ov_drop", i), int'(out_valid), 0);
            check($sformatf("vec%0d_fen_drop", i), int'(fifo_enable), 0);
        end
        check("no_drops_yet", int'(drop_count), 0);

        // Strobes on E0 and E1: second one is rejected.
        dry_in = 12'sd50; delayed_in = '0; gain = '0;
        sample_valid = 1'b1;
        @(negedge clk);
        @(negedge clk);
        sample_valid = 1'b0;
        cnt = 0;
        repeat (5) begin
            @(negedge clk);
            if (out_valid) cnt++;
        end
        check("e0e1_results", cnt, 1);
        check("e0e1_drop", int'(drop_count), 1);

        // Strobes on E0 and E3: both accepted.
        run_sample(10, 0, 0, wet, fin, fen);
        check("e0e3_first", wet, 10);
        run_sample(20, 40, 128, wet, fin, fen);
        check("e0e3_second", wet, 40);
        check("e0e3_drop", int'(drop_count), 1);
        @(negedge clk);

        // Held strobe: accept, drop, drop repeating; counter saturates.
        rstn = 1'b0;
        @(negedge clk);
        rstn = 1'b1;
        dry_in = 12'sd300; gain = '0;
        sample_valid = 1'b1;
        repeat (30) @(negedge clk);
        check("hold30_drop", int'(drop_count), 20);
        repeat (370) @(negedge clk);
        check("hold400_drop_sat", int'(drop_count), 255);
        sample_valid = 1'b0;
        repeat (4) @(negedge clk);
        check("hold_last_wet", int'(wet_out), 300);

        // Reset asserted during SUM abandons the sample.
        dry_in = 12'sd77; sample_valid = 1'b1;
        @(negedge clk);
        sample_valid = 1'b0;
        @(negedge clk);
        check("mid_busy_sum", int'(busy), 1);
        rstn = 1'b0;
        #1;
        check("mid_wet", int'(wet_out), 0);
        check("mid_fifo_in", int'(fifo_in), 0);
        check("mid_busy", int'(busy), 0);
        check("mid_drop", int'(drop_count), 0);
        cnt = 0;
        repeat (3) begin
            @(negedge clk);
            if (fifo_enable || out_valid) cnt++;
        end
        rstn = 1'b1;
        repeat (4) begin
            @(negedge clk);
            if (fifo_enable || out_valid) cnt++;
        end
        check("mid_no_pulse", cnt, 0);

        // Closed loop with a 10-deep delay line, gain 1/2, impulse input.
        foreach (hist[j]) hist[j] = '0;
        for (int k = 0; k <= 30; k++) begin
            int exp;
            run_sample((k == 0) ? 1024 : 0, int'(hist[9]), 128, wet, fin, fen);
            exp = (k == 0) ? 1024 : (k == 10) ? 512 : (k == 20) ? 256 : (k == 30) ? 128 : 0;
            check($sformatf("loop_k%0d", k), wet, exp);
            if (fen) begin
                for (int j = 9; j > 0; j--) hist[j] = hist[j-1];
                hist[0] = 12'(fin);
            end
        end
        @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running, expected finished");
        $fatal(1, "timeout");
    end
endmodule
